game_flow_ctrl: RTL and testbench



---
 rtl/game_flow_ctrl_pkg.sv | 29 ++
 rtl/game_flow_ctrl_if.sv | 42 ++++
 rtl/game_flow_ctrl_bcd_counter.sv | 66 ++++++
 rtl/game_flow_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_flow_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and helpers for the game-flow sequencer.
//   game_state_t : MENU / PLAY / PAUSE / OVER encoding (matches the 2-bit
//                  state output seen by the HEX / LED logic)
//   bcd_digit_t  : one packed BCD digit
//   BCD_MAX      : largest legal BCD digit value
//   clog2_min1   : counter/field width helper that never returns 0
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Width needed to hold 0..n-1, but at least one bit so that a
  // degenerate parameter choice still yields a legal vector.
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl_if
// Bundles the game-flow sequencer's input and output signals.
//   master : the surrounding system (VGA sync, keyboard decode, collision
//            logic) -- drives vs, start_req, pause_req, diff_sel, crash,
//            star_collect and observes the status outputs.
//   slave  : game_flow_ctrl itself.
// Parameters:
//   NUM_DIGITS : BCD score digits (score/high_score are 4*NUM_DIGITS bits)
//   LEVEL_W    : width of diff_sel / level
// ---------------------------------------------------------------------------
interface game_flow_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int LEVEL_W    = 2
);

  logic                    vs;
  logic                    start_req;
  logic                    pause_req;
  logic [LEVEL_W-1:0]      diff_sel;
  logic                    crash;
  logic                    star_collect;

  logic [1:0]              state;
  logic                    play_en;
  logic                    frame_tick;
  logic                    game_reset;
  logic [LEVEL_W-1:0]      level;
  logic [4*NUM_DIGITS-1:0] score;
  logic [4*NUM_DIGITS-1:0] high_score;

  modport master (
    output vs, start_req, pause_req, diff_sel, crash, star_collect,
    input  state, play_en, frame_tick, game_reset, level, score, high_score
  );

  modport slave (
    input  vs, start_req, pause_req, diff_sel, crash, star_collect,
    output state, play_en, frame_tick, game_reset, level, score, high_score
  );

endinterface

// File: rtl/game_flow_ctrl_bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter
// Saturating multi-digit BCD score register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous clear to zero (wins over enable)
//   enable      : load the incremented value this cycle
//   inc_one     : +1 at digit 0
//   inc_ten     : +1 at digit 1 (+10); both together give +11
//   value       : packed BCD value, digit 0 in the LSBs
//   saturated   : value is all nines
//   carry_d2    : the pending increment carries out of digit 1 into digit 2
// Any carry out of the top digit clamps the result to all nines.
// ---------------------------------------------------------------------------
module bcd_counter
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    inc_one,
  input  logic                    inc_ten,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    saturated,
  output logic                    carry_d2
);

  localparam logic [4*NUM_DIGITS-1:0] ALL_NINES = {NUM_DIGITS{BCD_MAX}};

  logic [4*NUM_DIGITS-1:0] sum;
  logic [4*NUM_DIGITS-1:0] next_value;
  logic [4:0]              digit_sum;
  logic                    ripple;

  // Ripple-carry BCD add. A digit never sees more than 9+1+1, so one
  // subtract-ten correction per digit is enough.
  always_comb begin
    sum       = '0;
    digit_sum = '0;
    ripple    = 1'b0;
    carry_d2  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_sum = {1'b0, value[4*i +: 4]} + {4'b0, ripple};
      if (i == 0) digit_sum = digit_sum + {4'b0, inc_one};
      if (i == 1) digit_sum = digit_sum + {4'b0, inc_ten};
      ripple = (digit_sum > {1'b0, BCD_MAX});
      if (ripple) sum[4*i +: 4] = 4'(digit_sum - 5'd10);
      else        sum[4*i +: 4] = digit_sum[3:0];
      if (i == 1) carry_d2 = ripple;
    end
    next_value = ripple ? ALL_NINES : sum;
  end

  assign saturated = (value == ALL_NINES);

  // Score register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      value <= '0;
    else if (clear)  value <= '0;
    else if (enable) value <= next_value;
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl
// Registered game-flow sequencer: MENU/PLAY/PAUSE/OVER state machine,
// gated per-frame tick, one-cycle object reset per new game, BCD score with
// level progression and optional high score.
// Ports:
//   Clk      : system clock
//   Reset_n  : asynchronous active-low reset
//   bus      : game_flow_ctrl_if.slave
//              in : vs, start_req, pause_req, diff_sel, crash, star_collect
//              out: state, play_en, frame_tick, game_reset, level, score,
//                   high_score
// Configuration macro:
//   GAME_HIGH_SCORE_EN : keep the best score across games (else tied to 0)
// ---------------------------------------------------------------------------
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int NUM_LEVELS       = 4,
  parameter int FRAMES_PER_POINT = 60,
  parameter int OVER_FRAMES      = 600
) (
  input  logic            Clk,
  input  logic            Reset_n,
  game_flow_ctrl_if.slave bus
);

  localparam int LEVEL_W = clog2_min1(NUM_LEVELS);
  localparam int FC_W    = clog2_min1(FRAMES_PER_POINT);
  localparam int OC_W    = clog2_min1(OVER_FRAMES);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [FC_W-1:0]    FRAME_LAST = FC_W'(FRAMES_PER_POINT - 1);
  localparam logic [OC_W-1:0]    OVER_LAST  = OC_W'(OVER_FRAMES - 1);

  logic [2:0]              vs_sync;
  logic [2:0]              start_sync;
  logic [2:0]              pause_sync;
  logic                    vs_rise;
  logic                    start_rise;
  logic                    pause_rise;

  game_state_t             state_q;
  game_state_t             state_d;
  logic                    play_en_q;
  logic                    play_en_d;
  logic                    frame_tick_q;
  logic                    frame_tick_d;
  logic                    game_reset_q;
  logic                    game_reset_d;

  logic [LEVEL_W-1:0]      level_q;
  logic [LEVEL_W-1:0]      start_level;
  logic [FC_W-1:0]         frame_cnt;
  logic [OC_W-1:0]         over_cnt;

  logic                    score_upd;
  logic                    score_en;
  logic                    point_inc;
  logic                    enter_menu;
  logic                    score_clear;
  logic                    score_sat;
  logic                    carry_d2;
  logic                    level_up;
  logic [4*NUM_DIGITS-1:0] score_val;

  // Bits [1:0] are the two-flop synchroniser, bit [2] remembers the previous
  // synchronised level so a held key or a long vs pulse gives one edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_sync    <= '0;
      start_sync <= '0;
      pause_sync <= '0;
    end else begin
      vs_sync    <= {vs_sync[1:0],    bus.vs};
      start_sync <= {start_sync[1:0], bus.start_req};
      pause_sync <= {pause_sync[1:0], bus.pause_req};
    end
  end

  assign vs_rise    = vs_sync[1]    & ~vs_sync[2];
  assign start_rise = start_sync[1] & ~start_sync[2];
  assign pause_rise = pause_sync[1] & ~pause_sync[2];

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= MENU;
    else          state_q <= state_d;
  end

  // Next-state logic; crash outranks a pause edge while playing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MENU:  if (start_rise) state_d = PLAY;
      PLAY:  begin
        if (bus.crash)       state_d = OVER;
        else if (pause_rise) state_d = PAUSE;
      end
      PAUSE: if (pause_rise) state_d = PLAY;
      OVER:  begin
        if (start_rise)                           state_d = PLAY;
        else if (vs_rise && over_cnt == OVER_LAST) state_d = MENU;
      end
      default: state_d = MENU;
    endcase
  end

  // Output decode from the upcoming state, so the registered outputs line
  // up with the cycle in which state_q takes its new value.
  always_comb begin
    play_en_d    = (state_d == PLAY);
    game_reset_d = (state_q == MENU || state_q == OVER) && (state_d == PLAY);
    frame_tick_d = vs_rise && (state_q == PLAY) && (state_d == PLAY);
  end

  // Output registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      play_en_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      game_reset_q <= 1'b0;
    end else begin
      play_en_q    <= play_en_d;
      frame_tick_q <= frame_tick_d;
      game_reset_q <= game_reset_d;
    end
  end

  // Score and level only move while playing and not in the crash cycle.
  assign score_upd   = (state_q == PLAY) && !bus.crash;
  assign score_en    = score_upd && !score_sat;
  assign point_inc   = vs_rise && (frame_cnt == FRAME_LAST);
  assign enter_menu  = (state_q == OVER) && (state_d == MENU);
  assign score_clear = game_reset_d || enter_menu;
  assign level_up    = score_en && carry_d2;
  assign start_level = (bus.diff_sel > LEVEL_MAX) ? LEVEL_MAX : bus.diff_sel;

  bcd_counter #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_score (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .clear     (score_clear),
    .enable    (score_en),
    .inc_one   (point_inc),
    .inc_ten   (bus.star_collect),
    .value     (score_val),
    .saturated (score_sat),
    .carry_d2  (carry_d2)
  );

  // Frame counter: one point every FRAMES_PER_POINT raw ticks in PLAY.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                   frame_cnt <= '0;
    else if (game_reset_d)          frame_cnt <= '0;
    else if (score_upd && vs_rise)  frame_cnt <= (frame_cnt == FRAME_LAST) ? '0
                                                 : frame_cnt + FC_W'(1);
  end

  // Idle timer for the automatic return from OVER to MENU.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)              over_cnt <= '0;
    else if (state_q != OVER)  over_cnt <= '0;
    else if (vs_rise)          over_cnt <= over_cnt + OC_W'(1);
  end

  // Difficulty level: loaded at game start, bumped on each hundred crossed.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                             level_q <= '0;
    else if (game_reset_d)                    level_q <= start_level;
    else if (enter_menu)                      level_q <= '0;
    else if (level_up && level_q != LEVEL_MAX) level_q <= level_q + LEVEL_W'(1);
  end

`ifdef GAME_HIGH_SCORE_EN
  logic [4*NUM_DIGITS-1:0] high_q;

  // Packed BCD orders the same as binary, so a plain magnitude compare is
  // the most-significant-digit-first BCD compare.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) high_q <= '0;
    else if (state_q == PLAY && state_d == OVER && score_val > high_q)
      high_q <= score_val;
  end

  assign bus.high_score = high_q;
`else
  assign bus.high_score = '0;
`endif

  assign bus.state      = state_q;
  assign bus.play_en    = play_en_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.game_reset = game_reset_q;
  assign bus.level      = level_q;
  assign bus.score      = score_val;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_flow_ctrl
// Self-checking bench for game_flow_ctrl: a cycle-exact vector table for the
// start / tick / star / pause / crash sequence, then hand-written sequences
// for point accrual, level-up, saturation, auto-return to MENU, high score
// and mid-game reset. Honors GAME_HIGH_SCORE_EN for high_score expectations.
// ---------------------------------------------------------------------------
module tb_game_flow_ctrl;

  localparam logic [1:0] ST_MENU  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

`ifdef GAME_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  typedef struct {
    logic        vs;
    logic        start;
    logic        pause;
    logic        crash;
    logic        star;
    logic [1:0]  diff;
    logic [38:0] expected;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   grSeen = 0;
  vec_t vecs [20];

  game_flow_ctrl_if #(.NUM_DIGITS(4), .LEVEL_W(2)) bus ();

  game_flow_ctrl #(
    .NUM_DIGITS       (4),
    .NUM_LEVELS       (4),
    .FRAMES_PER_POINT (60),
    .OVER_FRAMES      (600)
  ) dut (
    .Clk     (clk),
    .Reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hsExp(input logic [15:0] v);
    return HS_EN ? v : 16'h0000;
  endfunction

  function automatic vec_t mk(input logic iVs, iStart, iPause, iCrash, iStar,
                              input logic [1:0] iDiff, input logic [1:0] eSt,
                              input logic ePlay, eTick, eGr,
                              input logic [1:0] eLvl, input logic [15:0] eSc, eHs);
    vec_t v;
    v.vs       = iVs;
    v.start    = iStart;
    v.pause    = iPause;
    v.crash    = iCrash;
    v.star     = iStar;
    v.diff     = iDiff;
    v.expected = {eSt, ePlay, eTick, eGr, eLvl, eSc, eHs};
    return v;
  endfunction

  function automatic logic [38:0] observed();
    return {bus.state, bus.play_en, bus.frame_tick, bus.game_reset,
            bus.level, bus.score, bus.high_score};
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.vs           = v.vs;
    bus.start_req    = v.start;
    bus.pause_req    = v.pause;
    bus.crash        = v.crash;
    bus.star_collect = v.star;
    bus.diff_sel     = v.diff;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vsPulses(input int n);
    repeat (n) begin
      bus.vs = 1'b1;
      idle(2);
      bus.vs = 1'b0;
      idle(2);
    end
  endtask

  // Star arrives in the same cycle the synchronised vs edge is seen.
  task automatic vsPulseWithStar();
    bus.vs = 1'b1;
    idle(2);
    bus.star_collect = 1'b1;
    bus.vs = 1'b0;
    idle(1);
    bus.star_collect = 1'b0;
    idle(1);
  endtask

  task automatic holdStar(input int n);
    bus.star_collect = 1'b1;
    idle(n);
    bus.star_collect = 1'b0;
    idle(2);
  endtask

  task automatic crashPulse();
    bus.crash = 1'b1;
    idle(1);
    bus.crash = 1'b0;
    idle(1);
  endtask

  task automatic pressKey(input bit isStart);
    if (isStart) bus.start_req = 1'b1;
    else         bus.pause_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.game_reset) grSeen++;
    end
    bus.start_req = 1'b0;
    bus.pause_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.game_reset) grSeen++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Row i: inputs held over posedge i, outputs checked at the next negedge.
    vecs[0]  = mk(0,1,0,0,0,2'd2, ST_MENU, 0,0,0,2'd0,16'h0000,16'h0);
    vecs[1]  = mk(0,1,0,0,0,2'd2, ST_MENU, 0,0,0,2'd0,16'h0000,16'h0);
    vecs[2]  = mk(0,1,0,0,0,2'd2, ST_PLAY, 1,0,1,2'd2,16'h0000,16'h0);
    vecs[3]  = mk(0,1,0,0,0,2'd2, ST_PLAY, 1,0,0,2'd2,16'h0000,16'h0);
    vecs[4]  = mk(1,0,0,0,0,2'd2, ST_PLAY, 1,0,0,2'd2,16'h0000,16'h0);
    vecs[5]  = mk(1,0,0,0,0,2'd2, ST_PLAY, 1,0,0,2'd2,16'h0000,16'h0);
    vecs[6]  = mk(1,0,0,0,0,2'd2, ST_PLAY, 1,1,0,2'd2,16'h0000,16'h0);
    vecs[7]  = mk(0,0,0,0,0,2'd2, ST_PLAY, 1,0,0,2'd2,16'h0000,16'h0);
    vecs[8]  = mk(0,0,0,0,1,2'd2, ST_PLAY, 1,0,0,2'd2,16'h0010,16'h0);
    vecs[9]  = mk(0,0,0,0,0,2'd2, ST_PLAY, 1,0,0,2'd2,16'h0010,16'h0);
    vecs[10] = mk(0,0,1,0,0,2'd2, ST_PLAY, 1,0,0,2'd2,16'h0010,16'h0);
    vecs[11] = mk(0,0,1,0,0,2'd2, ST_PLAY, 1,0,0,2'd2,16'h0010,16'h0);
    vecs[12] = mk(0,0,1,0,0,2'd2, ST_PAUSE,0,0,0,2'd2,16'h0010,16'h0);
    vecs[13] = mk(0,0,0,1,0,2'd2, ST_PAUSE,0,0,0,2'd2,16'h0010,16'h0);
    vecs[14] = mk(0,0,0,1,1,2'd2, ST_PAUSE,0,0,0,2'd2,16'h0010,16'h0);
    vecs[15] = mk(0,0,1,0,0,2'd2, ST_PAUSE,0,0,0,2'd2,16'h0010,16'h0);
    vecs[16] = mk(0,0,1,0,0,2'd2, ST_PAUSE,0,0,0,2'd2,16'h0010,16'h0);
    vecs[17] = mk(0,0,1,0,0,2'd2, ST_PLAY, 1,0,0,2'd2,16'h0010,16'h0);
    vecs[18] = mk(0,0,0,1,1,2'd2, ST_OVER, 0,0,0,2'd2,16'h0010,hsExp(16'h0010));
    vecs[19] = mk(0,0,0,0,0,2'd2, ST_OVER, 0,0,0,2'd2,16'h0010,hsExp(16'h0010));

    reset_n          = 1'b0;
    bus.vs           = 1'b0;
    bus.start_req    = 1'b0;
    bus.pause_req    = 1'b0;
    bus.crash        = 1'b0;
    bus.star_collect = 1'b0;
    bus.diff_sel     = 2'd2;
    idle(3);
    checkOutput("reset_state", 64'(observed()), 64'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), 64'(observed()), 64'(vecs[i].expected));
    end

    // OVER with no keys: the 600th raw tick returns to MENU and clears.
    $display("[TB] auto-return from OVER");
    vsPulses(599);
    checkOutput("over_599", {bus.state, bus.level, bus.score}, {ST_OVER, 2'd2, 16'h0010});
    vsPulses(1);
    checkOutput("over_600", {bus.state, bus.level, bus.score}, {ST_MENU, 2'd0, 16'h0000});
    checkOutput("hs_after_0010", bus.high_score, hsExp(16'h0010));

    // New game from MENU at level 0, points from frames.
    bus.diff_sel = 2'd0;
    grSeen = 0;
    pressKey(1'b1);
    checkOutput("menu_start_gr", grSeen, 1);
    checkOutput("menu_start", {bus.state, bus.level, bus.score}, {ST_PLAY, 2'd0, 16'h0000});
    vsPulses(59);
    checkOutput("frames_59", bus.score, 16'h0000);
    vsPulses(1);
    checkOutput("frames_60", bus.score, 16'h0001);
    vsPulses(59);
    vsPulseWithStar();
    checkOutput("point_plus_star", bus.score, 16'h0012);

    // Crossing 100 via a point raises the level; it saturates at 3.
    $display("[TB] level progression");
    holdStar(8);
    checkOutput("stars_to_92", {bus.level, bus.score}, {2'd0, 16'h0092});
    vsPulses(420);
    checkOutput("points_to_99", {bus.level, bus.score}, {2'd0, 16'h0099});
    vsPulses(60);
    checkOutput("cross_100", {bus.level, bus.score}, {2'd1, 16'h0100});
    holdStar(20);
    checkOutput("cross_300", {bus.level, bus.score}, {2'd3, 16'h0300});
    holdStar(10);
    checkOutput("level_sat", {bus.level, bus.score}, {2'd3, 16'h0400});
    crashPulse();
    checkOutput("crash_0400", {bus.state, bus.level, bus.score}, {ST_OVER, 2'd3, 16'h0400});
    checkOutput("hs_after_0400", bus.high_score, hsExp(16'h0400));

    // Replay from OVER, then drive the score into saturation.
    $display("[TB] saturation");
    bus.diff_sel = 2'd3;
    grSeen = 0;
    pressKey(1'b1);
    checkOutput("over_start_gr", grSeen, 1);
    checkOutput("over_start", {bus.state, bus.level, bus.score}, {ST_PLAY, 2'd3, 16'h0000});
    holdStar(1000);
    checkOutput("sat_9999", {bus.state, bus.level, bus.score}, {ST_PLAY, 2'd3, 16'h9999});
    holdStar(1);
    checkOutput("sat_hold", bus.score, 16'h9999);
    crashPulse();
    checkOutput("hs_after_9999", bus.high_score, hsExp(16'h9999));

    // A lower game must not replace the high score.
    bus.diff_sel = 2'd1;
    pressKey(1'b1);
    holdStar(3);
    checkOutput("game_0030", {bus.state, bus.level, bus.score}, {ST_PLAY, 2'd1, 16'h0030});
    crashPulse();
    checkOutput("crash_0030", {bus.state, bus.level, bus.score}, {ST_OVER, 2'd1, 16'h0030});
    checkOutput("hs_kept", bus.high_score, hsExp(16'h9999));

    // Asynchronous reset in the middle of a game.
    $display("[TB] mid-game reset");
    pressKey(1'b1);
    holdStar(4);
    checkOutput("pre_reset", {bus.state, bus.score}, {ST_PLAY, 16'h0040});
    #2 reset_n = 1'b0;
    #1 checkOutput("async_reset", 64'(observed()), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    checkOutput("after_reset", 64'(observed()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
